// File: rtl/tof_pkg.sv
// rtl/tof_pkg.sv - shared constants, FSM encoding and BRAM address packing for the ToF frame collector
package tof_pkg;

  localparam int N_SENSORS_D = 8;
  localparam int ZONES_D     = 64;
  localparam int ZONE_W_D    = 6;
  localparam int DATA_W_D    = 16;
  localparam int IDX_W_D     = 3;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SWAP    = 2'd1,
    STALL   = 2'd2
  } state_t;

  // Packs {bank, idx, zone} into the low bits of a 32-bit word; the caller
  // truncates to its own address width so the function works for any sizing.
  function automatic logic [31:0] pack_addr(input logic        bank,
                                            input logic [31:0] idx,
                                            input logic [31:0] zone,
                                            input int          idx_w,
                                            input int          zone_w);
    return ({31'd0, bank} << (idx_w + zone_w)) | (idx << zone_w) | zone;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with one-hot grant, grant index and pointer advance
// Ports: clk, reset (async, active-low), req (request vector), adv (allow pointer update),
//        gnt (one-hot grant), gnt_idx (index of winner), gnt_valid (any grant this cycle).
module rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  logic [IW-1:0] ptr;
  int            cand;

  // Search starts at ptr and wraps; the first full request wins.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = 0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      if (!gnt_valid && req[cand[IW-1:0]]) begin
        gnt_valid            = 1'b1;
        gnt[cand[IW-1:0]]    = 1'b1;
        gnt_idx              = cand[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (adv && gnt_valid) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/tof_frame_collector.sv
// rtl/tof_frame_collector.sv - collects per-channel ToF zone samples into ping-pong BRAM frame banks
// Ports: clk, reset (async, active-low); tof_dr/tof_data per-channel sample strobes and {zone, sample};
//        chan_en channel mask; mem_we/mem_addr/mem_din BRAM write port ({bank, sensor, zone});
//        frame_rdy/frame_bank full-frame indication, frame_ack reader release; overrun sticky drop flag.
module tof_frame_collector
  import tof_pkg::*;
#(
  parameter int N_SENSORS = N_SENSORS_D,
  parameter int ZONES     = ZONES_D,
  parameter int ZONE_W    = ZONE_W_D,
  parameter int DATA_W    = DATA_W_D,
  parameter int IDX_W     = IDX_W_D
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [N_SENSORS-1:0]                   tof_dr,
  input  logic [N_SENSORS*(ZONE_W+DATA_W)-1:0]   tof_data,
  input  logic [N_SENSORS-1:0]                   chan_en,
  output logic                                   mem_we,
  output logic [IDX_W+ZONE_W:0]                  mem_addr,
  output logic [DATA_W-1:0]                      mem_din,
  output logic                                   frame_rdy,
  output logic                                   frame_bank,
  input  logic                                   frame_ack,
  output logic                                   overrun
);

  localparam int SW = ZONE_W + DATA_W;
  localparam int AW = 1 + IDX_W + ZONE_W;
  localparam logic [ZONE_W:0] FULL_CNT = (ZONE_W + 1)'(ZONES);
  localparam logic [ZONE_W:0] CNT_ONE  = (ZONE_W + 1)'(1);

  state_t               state;
  logic                 fill_bank;
  logic [N_SENSORS-1:0] hold_full;
  logic [SW-1:0]        hold [N_SENSORS];
  logic [ZONE_W:0]      cnt [N_SENSORS];
  logic [ZONE_W:0]      cnt_nxt [N_SENSORS];

  logic [N_SENSORS-1:0] gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_valid;
  logic                 collecting;
  logic [SW-1:0]        gnt_sample;
  logic                 gnt_sat;
  logic                 do_write;
  logic                 frame_done;
  logic                 ack_ok;

  assign collecting = (state == COLLECT);
  assign ack_ok     = frame_ack && frame_rdy;

  // Grants happen only while collecting; SWAP and STALL leave samples parked.
  rr_arbiter #(.N(N_SENSORS), .IW(IDX_W)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (hold_full & {N_SENSORS{collecting}}),
    .adv       (collecting),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    gnt_sample = hold[gnt_idx];
    // A grant to a channel that already has its full frame is a drop, not a write.
    gnt_sat    = gnt_valid && (cnt[gnt_idx] == FULL_CNT);
    do_write   = gnt_valid && !gnt_sat;
    frame_done = |chan_en;
    for (int i = 0; i < N_SENSORS; i++) begin
      cnt_nxt[i] = cnt[i];
      if (do_write && gnt[i]) cnt_nxt[i] = cnt[i] + CNT_ONE;
      // Looking at the post-write count lets COLLECT leave on the last write's cycle.
      if (chan_en[i] && (cnt_nxt[i] != FULL_CNT)) frame_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= COLLECT;
      fill_bank  <= 1'b0;
      hold_full  <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      frame_rdy  <= 1'b0;
      frame_bank <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < N_SENSORS; i++) begin
        hold[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      mem_we <= do_write;
      if (do_write) begin
        mem_addr <= AW'(pack_addr(fill_bank, 32'(gnt_idx), 32'(gnt_sample[SW-1:DATA_W]),
                                  IDX_W, ZONE_W));
        mem_din  <= gnt_sample[DATA_W-1:0];
      end
      if (gnt_sat) overrun <= 1'b1;

      for (int i = 0; i < N_SENSORS; i++) begin
        // A register being granted this edge counts as empty, so it can reload at once.
        if (tof_dr[i] && chan_en[i] && (!hold_full[i] || gnt[i])) begin
          hold_full[i] <= 1'b1;
          hold[i]      <= tof_data[i*SW +: SW];
        end else begin
          if (tof_dr[i] && chan_en[i]) overrun <= 1'b1;
          if (gnt[i]) hold_full[i] <= 1'b0;
        end
        cnt[i] <= cnt_nxt[i];
      end

      if (ack_ok) frame_rdy <= 1'b0;

      case (state)
        COLLECT: if (frame_done) state <= SWAP;
        SWAP: begin
          // A same-cycle ack has already released the reader bank.
          if (frame_rdy && !frame_ack) begin
            state <= STALL;
          end else begin
            frame_bank <= fill_bank;
            frame_rdy  <= 1'b1;
            fill_bank  <= ~fill_bank;
            for (int i = 0; i < N_SENSORS; i++) cnt[i] <= '0;
            state <= COLLECT;
          end
        end
        STALL:   if (ack_ok) state <= SWAP;
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_tof_frame_collector.sv
// tb/tb_tof_frame_collector.sv - self-checking bench for tof_frame_collector
module tb_tof_frame_collector;

  localparam int N  = 8;
  localparam int SW = 22;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   tof_dr;
  logic [N*SW-1:0] tof_data;
  logic [N-1:0]   chan_en;
  logic           mem_we;
  logic [9:0]     mem_addr;
  logic [15:0]    mem_din;
  logic           frame_rdy;
  logic           frame_bank;
  logic           frame_ack;
  logic           overrun;

  always #5 clk = ~clk;

  tof_frame_collector dut (
    .clk        (clk),
    .reset      (reset),
    .tof_dr     (tof_dr),
    .tof_data   (tof_data),
    .chan_en    (chan_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .frame_rdy  (frame_rdy),
    .frame_bank (frame_bank),
    .frame_ack  (frame_ack),
    .overrun    (overrun)
  );

  typedef struct packed {
    logic [9:0]  addr;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    int          ch;
    int          z;
    logic [15:0] d;
    logic [9:0]  ea;
    logic [15:0] ed;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[5];
  int   checks = 0;
  int   errors = 0;
  int   wr_count = 0;
  int   w0;
  bit   found;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset && mem_we) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h required no write (t=%0t)",
                 mem_addr, mem_din, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
        chk("wr_data", 32'(mem_din), 32'(e.data));
      end
      wr_count++;
    end
  end

  function automatic logic [15:0] smp(input int ch, input int z);
    return 16'(32'h8000 | (z << 4) | ch);
  endfunction

  task automatic push(input logic bank, input int ch, input int z, input logic [15:0] d);
    logic [9:0] a;
    a = {bank, 3'(ch), 6'(z)};
    sb.push_back({a, d});
  endtask

  task automatic set_ch(input int ch, input int z, input logic [15:0] d);
    tof_data[ch*SW +: SW] = {6'(z), d};
  endtask

  task automatic burst(input logic [7:0] mask, input int z, input logic bank, input bit do_push);
    for (int c = 0; c < N; c++) begin
      if (mask[c]) begin
        set_ch(c, z, smp(c, z));
        if (do_push) push(bank, c, z, smp(c, z));
      end
    end
    tof_dr = mask;
    @(negedge clk);
    tof_dr = '0;
  endtask

  // One burst of all eight channels every 8 cycles keeps every holding register drained in time.
  task automatic feed(input logic bank, input int z0, input int z1);
    for (int z = z0; z <= z1; z++) begin
      burst(8'hFF, z, bank, 1'b1);
      repeat (7) @(negedge clk);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_mem_we",     32'(mem_we),     0);
    chk("rst_mem_addr",   32'(mem_addr),   0);
    chk("rst_mem_din",    32'(mem_din),    0);
    chk("rst_frame_rdy",  32'(frame_rdy),  0);
    chk("rst_frame_bank", 32'(frame_bank), 0);
    chk("rst_overrun",    32'(overrun),    0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    tof_dr    = '0;
    tof_data  = '0;
    chan_en   = '0;
    frame_ack = 1'b0;
    @(negedge clk);
    do_reset();

    // Table of isolated single-channel samples: address packing and data path.
    tbl[0] = '{0, 0,  16'h0000, 10'h000, 16'h0000};
    tbl[1] = '{7, 63, 16'hFFFF, 10'h1FF, 16'hFFFF};
    tbl[2] = '{3, 10, 16'hBEEF, 10'h0CA, 16'hBEEF};
    tbl[3] = '{5, 33, 16'h1234, 10'h161, 16'h1234};
    tbl[4] = '{1, 62, 16'hA5A5, 10'h07E, 16'hA5A5};
    chan_en = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      set_ch(tbl[i].ch, tbl[i].z, tbl[i].d);
      sb.push_back({tbl[i].ea, tbl[i].ed});
      tof_dr = 8'(1 << tbl[i].ch);
      @(negedge clk);
      tof_dr = '0;
      @(negedge clk);
      chk("tbl_we",   32'(mem_we),   1);
      chk("tbl_addr", 32'(mem_addr), 32'(tbl[i].ea));
      chk("tbl_data", 32'(mem_din),  32'(tbl[i].ed));
      repeat (2) @(negedge clk);
    end
    drain();

    // Single channel frame on ch0.
    do_reset();
    chan_en = 8'h01;
    for (int i = 0; i < 64; i++) begin
      set_ch(0, i, 16'(16'h1000 + i));
      push(1'b0, 0, i, 16'(16'h1000 + i));
      tof_dr = 8'h01;
      @(negedge clk);
      tof_dr = '0;
      if (i == 0) chk("lat_not_1", 32'(mem_we), 0);
      @(negedge clk);
      chk("lat_2", 32'(mem_we), 1);
    end
    repeat (2) @(negedge clk);
    chk("single_rdy",  32'(frame_rdy),  1);
    chk("single_bank", 32'(frame_bank), 0);
    set_ch(0, 5, 16'h2005);
    push(1'b1, 0, 5, 16'h2005);
    tof_dr = 8'h01;
    @(negedge clk);
    tof_dr = '0;
    drain();

    // Disabled channel pulses are ignored.
    do_reset();
    chan_en = 8'h01;
    set_ch(2, 1, 16'h7777);
    tof_dr = 8'h04;
    @(negedge clk);
    @(negedge clk);
    tof_dr = '0;
    repeat (5) @(negedge clk);
    chk("disabled_overrun", 32'(overrun), 0);

    // Fairness: 8 consecutive writes in order, then rotated start after a partial burst.
    do_reset();
    chan_en = 8'hFF;
    burst(8'hFF, 0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("fair_consec", 32'(mem_we), 1);
    end
    burst(8'h30, 1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    burst(8'hFF, 2, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) push(1'b0, (6 + k) % 8, 2, smp((6 + k) % 8, 2));
    drain();
    chk("fair_overrun", 32'(overrun), 0);

    // Holding register overflow on ch3.
    do_reset();
    chan_en = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      set_ch(c, 0, smp(c, 0));
      push(1'b0, c, 0, smp(c, 0));
    end
    tof_dr = 8'h0F;
    @(negedge clk);
    set_ch(3, 1, 16'hDEAD);
    tof_dr = 8'h08;
    @(negedge clk);
    tof_dr = '0;
    drain();
    chk("ovf_overrun", 32'(overrun), 1);

    // Backpressure: two frames without ack stall the collector.
    do_reset();
    chan_en = 8'hFF;
    feed(1'b0, 0, 63);
    repeat (4) @(negedge clk);
    chk("f0_rdy",  32'(frame_rdy),  1);
    chk("f0_bank", 32'(frame_bank), 0);
    feed(1'b1, 0, 63);
    repeat (4) @(negedge clk);
    chk("stall_rdy",  32'(frame_rdy),  1);
    chk("stall_bank", 32'(frame_bank), 0);
    burst(8'hFF, 0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk("stall_no_we", 32'(mem_we), 0);
    frame_ack = 1'b1;
    for (int c = 0; c < 8; c++) push(1'b0, c, 0, smp(c, 0));
    @(negedge clk);
    frame_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("unstall_rdy",  32'(frame_rdy),  1);
    chk("unstall_bank", 32'(frame_bank), 1);
    repeat (10) @(negedge clk);

    // Ack arriving in the SWAP cycle: no stall, bank toggles, frame_rdy stays high.
    feed(1'b0, 1, 62);
    burst(8'hFF, 63, 1'b0, 1'b1);
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      @(negedge clk);
      #1;
      if (mem_we && mem_addr == 10'h1FF) found = 1'b1;
    end
    chk("last_write_seen", 32'(found), 1);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    chk("ackswap_rdy",  32'(frame_rdy),  1);
    chk("ackswap_bank", 32'(frame_bank), 0);
    repeat (3) @(negedge clk);
    chk("ackswap_rdy_hold", 32'(frame_rdy), 1);
    burst(8'hFF, 0, 1'b1, 1'b1);
    drain();

    // Reset after 100 writes discards the partial frame.
    do_reset();
    chan_en = 8'hFF;
    w0 = wr_count;
    feed(1'b0, 0, 11);
    burst(8'hFF, 12, 1'b0, 1'b1);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      #1;
      if (wr_count - w0 >= 100) break;
    end
    chk("writes_before_reset", 32'(wr_count - w0), 100);
    do_reset();
    feed(1'b0, 0, 62);
    burst(8'h7F, 63, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    chk("rdy_before_last", 32'(frame_rdy), 0);
    burst(8'h80, 63, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("post_reset_rdy",  32'(frame_rdy),  1);
    chk("post_reset_bank", 32'(frame_bank), 0);
    drain();

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
